// File: rtl/invsqrt_arbiter.sv
// Round-robin front end sharing one fixed-latency inverse-sqrt pipeline among
// NUM_REQ requesters, with a tag pipe steering results into per-requester slots.

module invsqrt_arbiter_slot (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        issue,
    input  logic        retire,
    input  logic        ack,
    input  logic [31:0] result_in,
    output logic        rdy,
    output logic        inflight,
    output logic [31:0] result
);
    logic        rdy_q, rdy_d;
    logic        inflight_q, inflight_d;
    logic [31:0] result_q, result_d;

    // issue and retire never target the same slot in one cycle: issue needs ~inflight
    always_comb begin
        rdy_d      = rdy_q;
        inflight_d = inflight_q;
        result_d   = result_q;
        if (retire) begin
            rdy_d      = 1'b1;
            inflight_d = 1'b0;
            result_d   = result_in;
        end else if (ack && rdy_q) begin
            rdy_d = 1'b0;
        end
        if (issue) begin
            inflight_d = 1'b1;
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            rdy_q      <= 1'b0;
            inflight_q <= 1'b0;
            result_q   <= '0;
        end else begin
            rdy_q      <= rdy_d;
            inflight_q <= inflight_d;
            result_q   <= result_d;
        end
    end

    assign rdy      = rdy_q;
    assign inflight = inflight_q;
    assign result   = result_q;
endmodule

module invsqrt_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LAT     = 4
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    input  logic [NUM_REQ-1:0]    iReq,
    input  logic [NUM_REQ*32-1:0] iOperand,
    output logic [NUM_REQ-1:0]    oGrant,
    output logic [31:0]           oFPU_A,
    input  logic [31:0]           iFPU_Result,
    output logic [NUM_REQ-1:0]    oRdy,
    output logic [NUM_REQ*32-1:0] oResult,
    input  logic [NUM_REQ-1:0]    iAck,
    output logic                  oBusy
);
    localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0][31:0] operand;
    logic [NUM_REQ-1:0][31:0] result;
    logic [NUM_REQ-1:0]       inflight;
    logic [NUM_REQ-1:0]       rdy;
    logic [NUM_REQ-1:0]       elig;
    logic [NUM_REQ-1:0]       grant;
    logic [TAG_W-1:0]         gnt_idx;
    logic                     xfer;
    int                       scan_idx;

    logic [TAG_W-1:0]         ptr_q, ptr_d;
    logic [31:0]              fpu_a_q, fpu_a_d;
    // Stage 0 is loaded alongside oFPU_A; stage LAT lines up with iFPU_Result.
    logic [LAT:0]             vld_q, vld_d;
    logic [LAT:0][TAG_W-1:0]  tag_q, tag_d;

    assign operand = iOperand;
    assign elig    = iReq & ~inflight & ~rdy;

    always_comb begin
        grant    = '0;
        gnt_idx  = '0;
        xfer     = 1'b0;
        scan_idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = int'(ptr_q) + k;
            if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
            if (!xfer && elig[scan_idx]) begin
                xfer            = 1'b1;
                grant[scan_idx] = 1'b1;
                gnt_idx         = TAG_W'(scan_idx);
            end
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        fpu_a_d = fpu_a_q;
        if (xfer) begin
            ptr_d   = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + TAG_W'(1);
            fpu_a_d = operand[gnt_idx];
        end
        vld_d    = '0;
        tag_d    = '0;
        vld_d[0] = xfer;
        tag_d[0] = gnt_idx;
        for (int s = 1; s <= LAT; s++) begin
            vld_d[s] = vld_q[s-1];
            tag_d[s] = tag_q[s-1];
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            ptr_q   <= '0;
            fpu_a_q <= '0;
            vld_q   <= '0;
            tag_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            fpu_a_q <= fpu_a_d;
            vld_q   <= vld_d;
            tag_q   <= tag_d;
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
        invsqrt_arbiter_slot u_slot (
            .iCLK      (iCLK),
            .iRST_N    (iRST_N),
            .issue     (grant[i]),
            .retire    (vld_q[LAT] && (tag_q[LAT] == TAG_W'(i))),
            .ack       (iAck[i]),
            .result_in (iFPU_Result),
            .rdy       (rdy[i]),
            .inflight  (inflight[i]),
            .result    (result[i])
        );
    end

    assign oGrant  = grant;
    assign oFPU_A  = fpu_a_q;
    assign oRdy    = rdy;
    assign oResult = result;
    assign oBusy   = (|inflight) | (|rdy);
endmodule
